pre_trigger_receiver: RTL
=========================

# pre_trigger_receiver

Receive-side checker for the pre-trigger line. It decodes the fixed-width pre-trigger pulses on a single trigger wire into one-cycle strobes, counts them against an expected total, measures the leading-edge spacing, and flags malformed pulses. It sits at the input of the trigger path on the readout board, either downstream of the pre-trigger generator in loopback or behind the board's trigger input pin.

## Interface
Parameters:
- PULSE_WIDTH, default 3: required number of consecutive high samples per valid pulse.
- MIN_LOW, default 2: minimum low samples between a falling edge and the next rising edge.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- ena  in  1  receive enable.
- trig_in  in  1  pre-trigger line, synchronous to clk.
- ntrig  in  16  expected pulse total for the run.
- period  in  8  expected leading-edge spacing in cycles; 0 disables the spacing check.
- trig_valid  out  1  one-cycle strobe for each accepted pulse.
- trig_count  out  16  number of accepted pulses.
- gap_meas  out  8  last measured leading-edge spacing; saturates at 255.
- done  out  1  sticky; set when trig_count == ntrig.
- err_width  out  1  one-cycle strobe for a bad pulse width or short low time.
- err_gap  out  1  one-cycle strobe for a spacing mismatch.
- err_extra  out  1  one-cycle strobe for a valid pulse received after done.

## Operation
- trig_in passes through one register, trig_q. The FSM uses only trig_q.
- FSM states and transitions:
  - ARM: wait for trig_q == 0, then go to IDLE. ARM is the reset state and the state after any error.
  - IDLE: count low cycles in lo_cnt, saturating at MIN_LOW. When trig_q == 1:
    - if lo_cnt >= MIN_LOW, or this is the first pulse since ARM: go to HIGH, set hi_cnt = 1, mark a leading edge.
    - otherwise: pulse err_width and go to ARM.
  - HIGH: increment hi_cnt while trig_q == 1.
    - If hi_cnt would exceed PULSE_WIDTH: pulse err_width immediately and go to ARM.
    - When trig_q == 0 and hi_cnt == PULSE_WIDTH: the pulse is accepted; go to IDLE with lo_cnt = 1.
    - When trig_q == 0 and hi_cnt < PULSE_WIDTH: pulse err_width and go to IDLE with lo_cnt = 1.
- On an accepted pulse:
  - if done == 0: trig_valid = 1 for one cycle, trig_count += 1, and set done if the new count equals ntrig.
  - if done == 1: err_extra = 1 for one cycle; trig_count holds and trig_valid stays 0.
- Period counter:
  - On a leading edge it reloads to 1; otherwise it increments each cycle, saturating at 255.
  - On each leading edge after the first since reset: gap_meas takes the counter value. If period != 0 and that value != period, err_gap = 1 for one cycle.
  - Spacing is measured even for pulses later rejected for width.
- ntrig == 0: done is set by reset release and every accepted pulse raises err_extra.
- ena == 0: the FSM is forced to ARM and nothing is strobed. trig_count, gap_meas and done hold. The period counter restarts, so the first edge after re-enable produces no gap measurement.
- trig_count never wraps, because counting stops at done.

## Timing
- During rst, all outputs are 0, the FSM is in ARM, and all counters are 0. This applies when rst is asserted mid-pulse too; a pulse in progress is discarded.
- Let E0 be the clock edge at which trig_in is first sampled high for a correct pulse. trig_valid is high in the cycle after edge E0+PULSE_WIDTH+1, i.e. 4 edges after E0 at default parameters.
- trig_count and done update on the same edge as trig_valid.
- err_gap asserts one edge after the leading-edge sample of trig_q, aligned with the FSM's IDLE→HIGH transition.
- An overlong pulse raises err_width on the edge where hi_cnt would reach PULSE_WIDTH+1, i.e. the (PULSE_WIDTH+1)-th high sample of trig_q.
- Error strobes may coincide with one another (for example err_gap and err_width on the same pulse). Each is independent and lasts exactly one cycle.

## Test plan
- ntrig=4, period=10, four 3-high pulses 10 cycles apart → 4 trig_valid strobes, each 4 cycles after its rise; trig_count=4; done set with the 4th strobe; gap_meas=10; no errors.
- A fifth valid pulse after done → err_extra for one cycle; trig_count stays 4; no trig_valid.
- Pulse widths 2 and 4 → err_width once each; trig_count unchanged. The 4-wide pulse errors on its 4th high sample, and the FSM re-arms only after the line goes low.
- Two 3-wide pulses separated by 1 low cycle → the second raises err_width and is not counted.
- period=10 with pulses 12 apart → err_gap on the second leading edge and gap_meas=12; with period=0 no err_gap; spacing of 300 → gap_meas=255.
- Assert rst in the middle of a pulse, and separately drop ena in the middle of a pulse → no strobe for that pulse and outputs as specified; a clean pulse afterwards is accepted only once the line has been low at least once.

Source files
------------

// File: rtl/pre_trigger_receiver.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pre_trigger_receiver
// Description : Decodes fixed-width pre-trigger pulses into one-cycle strobes,
//               counts them against an expected total, measures leading-edge
//               spacing and flags malformed pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pre_trigger_receiver #(
  parameter int PULSE_WIDTH = 3,
  parameter int MIN_LOW     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        trig_in,
  input  logic [15:0] ntrig,
  input  logic [7:0]  period,
  output logic        trig_valid,
  output logic [15:0] trig_count,
  output logic [7:0]  gap_meas,
  output logic        done,
  output logic        err_width,
  output logic        err_gap,
  output logic        err_extra
);

  localparam int c_HI_W = $clog2(PULSE_WIDTH + 2);
  localparam int c_LO_W = $clog2(MIN_LOW + 2);
  localparam logic [c_HI_W-1:0] c_PW = c_HI_W'(PULSE_WIDTH);
  localparam logic [c_LO_W-1:0] c_ML = c_LO_W'(MIN_LOW);

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_IDLE = 2'd1,
    S_HIGH = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_trig_q;
  logic [c_LO_W-1:0]   r_lo_cnt, w_lo_nxt;
  logic [c_HI_W-1:0]   r_hi_cnt, w_hi_nxt;
  logic                r_first, w_first_nxt;
  logic                w_lead, w_accept, w_err_w;
  logic [15:0]         r_count, w_count_nxt;
  logic [7:0]          r_per_cnt, r_gap_meas;
  logic                r_seen_edge;
  logic                r_done, r_trig_valid, r_err_width, r_err_gap, r_err_extra;

  // Input register; deliberately not reset so ARM sees the real line level
  // straight after reset release (a pulse in progress must go low first).
  always_ff @(posedge clk) begin
    r_trig_q <= trig_in;
  end

  // FSM state and pulse-shape counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_ARM;
      r_lo_cnt <= '0;
      r_hi_cnt <= '0;
      r_first  <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_lo_cnt <= w_lo_nxt;
      r_hi_cnt <= w_hi_nxt;
      r_first  <= w_first_nxt;
    end
  end

  // Next-state decode, leading-edge marking and pulse classification.
  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo_cnt;
    w_hi_nxt    = r_hi_cnt;
    w_first_nxt = r_first;
    w_lead      = 1'b0;
    w_accept    = 1'b0;
    w_err_w     = 1'b0;
    if (!ena) begin
      w_state_nxt = S_ARM;
      w_lo_nxt    = '0;
      w_hi_nxt    = '0;
      w_first_nxt = 1'b1;
    end else begin
      case (r_state)
        S_ARM: begin
          w_first_nxt = 1'b1;
          if (!r_trig_q) begin
            w_state_nxt = S_IDLE;
            w_lo_nxt    = c_LO_W'(1);
          end
        end
        S_IDLE: begin
          if (r_trig_q) begin
            if ((r_lo_cnt >= c_ML) || r_first) begin
              w_state_nxt = S_HIGH;
              w_hi_nxt    = c_HI_W'(1);
              w_first_nxt = 1'b0;
              w_lead      = 1'b1;
            end else begin
              w_err_w     = 1'b1;
              w_state_nxt = S_ARM;
            end
          end else if (r_lo_cnt < c_ML) begin
            w_lo_nxt = r_lo_cnt + c_LO_W'(1);
          end
        end
        S_HIGH: begin
          if (r_trig_q) begin
            if (r_hi_cnt >= c_PW) begin
              // Overlong: flag on the sample that would exceed the width.
              w_err_w     = 1'b1;
              w_state_nxt = S_ARM;
            end else begin
              w_hi_nxt = r_hi_cnt + c_HI_W'(1);
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_lo_nxt    = c_LO_W'(1);
            if (r_hi_cnt == c_PW) w_accept = 1'b1;
            else                  w_err_w  = 1'b1;
          end
        end
        default: w_state_nxt = S_ARM;
      endcase
    end
  end

  assign w_count_nxt = (w_accept && !r_done) ? r_count + 16'd1 : r_count;

  // Accept bookkeeping, spacing measurement and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_done       <= 1'b0;
      r_trig_valid <= 1'b0;
      r_err_width  <= 1'b0;
      r_err_extra  <= 1'b0;
      r_err_gap    <= 1'b0;
      r_per_cnt    <= '0;
      r_gap_meas   <= '0;
      r_seen_edge  <= 1'b0;
    end else begin
      r_trig_valid <= w_accept && !r_done;
      r_err_extra  <= w_accept && r_done;
      r_err_width  <= w_err_w;
      r_err_gap    <= 1'b0;
      r_count      <= w_count_nxt;
      r_done       <= r_done || (w_count_nxt == ntrig);
      if (!ena) begin
        r_per_cnt   <= '0;
        r_seen_edge <= 1'b0;
      end else if (w_lead) begin
        r_per_cnt   <= 8'd1;
        r_seen_edge <= 1'b1;
        if (r_seen_edge) begin
          r_gap_meas <= r_per_cnt;
          r_err_gap  <= (period != 8'd0) && (r_per_cnt != period);
        end
      end else if (r_per_cnt != 8'hFF) begin
        r_per_cnt <= r_per_cnt + 8'd1;
      end
    end
  end

  assign trig_valid = r_trig_valid;
  assign trig_count = r_count;
  assign gap_meas   = r_gap_meas;
  assign done       = r_done;
  assign err_width  = r_err_width;
  assign err_gap    = r_err_gap;
  assign err_extra  = r_err_extra;

endmodule
`default_nettype wire
